// File: rtl/tft_sprite_bounce.sv
// ---------------------------------------------------------------------------
// tft_sprite_bounce
//
// Bouncing-sprite overlay for the TFT pixel pipeline. Sits between the TFT
// timing block (pix_x/pix_y) and the panel driver, compositing an
// IMG_W x IMG_H sprite (read from an external 1-cycle-latency ROM) over a
// selectable background. The sprite moves once per frame, reflecting off the
// panel edges; wall hits are counted.
//
// Ports
//   tft_clk     in   pixel clock
//   sys_rst_n   in   asynchronous active-low reset
//   pix_x/y     in   current pixel; values beyond the active area are blanking
//   pause       in   1 = hold sprite position (sampled at frame end)
//   key_en      in   1 = pixels equal to KEY_COLOR show the background
//   bg_mode     in   0 bars, 1 solid bg_color, 2 8x8 checker, 3 black
//   bg_color    in   RGB565 for solid mode and checker light squares
//   rom_data    in   sprite pixel, valid 1 cycle after rom_rd_en
//   rom_addr    out  sprite ROM address
//   rom_rd_en   out  ROM read strobe (pixel is inside the sprite window)
//   pix_data    out  RGB565 output pixel, 1 cycle after pix_x/pix_y
//   frame_tick  out  1-cycle pulse the cycle after the last active pixel
//   hit_cnt     out  saturating count of wall hits since reset
// ---------------------------------------------------------------------------
module tft_sprite_bounce #(
    parameter int          H_VALID   = 480,
    parameter int          V_VALID   = 272,
    parameter int          IMG_W     = 100,
    parameter int          IMG_H     = 100,
    parameter int          ADDR_W    = 14,
    parameter int          STEP_X    = 1,
    parameter int          STEP_Y    = 1,
    parameter logic [15:0] KEY_COLOR = 16'hF81F
) (
    input  logic              tft_clk,
    input  logic              sys_rst_n,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              pause,
    input  logic              key_en,
    input  logic [1:0]        bg_mode,
    input  logic [15:0]       bg_color,
    input  logic [15:0]       rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    output logic [15:0]       pix_data,
    output logic              frame_tick,
    output logic [15:0]       hit_cnt
);

    localparam int BAR_W = H_VALID / 10;

    localparam logic [10:0]        H_V       = 11'(H_VALID);
    localparam logic [10:0]        V_V       = 11'(V_VALID);
    localparam logic [10:0]        IMG_W_11  = 11'(IMG_W);
    localparam logic [10:0]        IMG_H_11  = 11'(IMG_H);
    localparam logic [10:0]        X_MAX     = 11'(H_VALID - IMG_W);
    localparam logic [10:0]        Y_MAX     = 11'(V_VALID - IMG_H);
    localparam logic signed [11:0] X_MAX_S   = 12'(H_VALID - IMG_W);
    localparam logic signed [11:0] Y_MAX_S   = 12'(V_VALID - IMG_H);
    localparam logic signed [11:0] STEP_X_S  = 12'(STEP_X);
    localparam logic signed [11:0] STEP_Y_S  = 12'(STEP_Y);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);

    localparam logic [15:0] C_RED    = 16'hF800;
    localparam logic [15:0] C_ORANGE = 16'hFD20;
    localparam logic [15:0] C_YELLOW = 16'hFFE0;
    localparam logic [15:0] C_GREEN  = 16'h07E0;
    localparam logic [15:0] C_CYAN   = 16'h07FF;
    localparam logic [15:0] C_BLUE   = 16'h001F;
    localparam logic [15:0] C_PURPLE = 16'h8010;
    localparam logic [15:0] C_BLACK  = 16'h0000;
    localparam logic [15:0] C_WHITE  = 16'hFFFF;
    localparam logic [15:0] C_GRAY   = 16'h8410;

    // dir_*: 0 = moving towards larger coordinates, 1 = towards smaller
    logic [10:0]       x_pos_q, x_pos_d;
    logic [10:0]       y_pos_q, y_pos_d;
    logic              dir_x_q, dir_x_d;
    logic              dir_y_q, dir_y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       hit_q, hit_d;
    logic              tick_q;
    logic              img_v_q;
    logic [15:0]       bg_q, bg_d;

    logic [10:0]        px11, py11;
    logic               fe;
    logic               in_win;
    logic               blank;
    logic [3:0]         bar_idx;
    logic signed [11:0] x_cur_s, y_cur_s;
    logic signed [11:0] nx_s, ny_s;
    logic               hit_x, hit_y;
    logic [1:0]         hit_inc;
    logic [16:0]        hit_sum;

    assign px11 = {1'b0, pix_x};
    assign py11 = {1'b0, pix_y};

    assign fe = (px11 == H_V - 11'd1) && (py11 == V_V - 11'd1);

    // The window always lies inside the active area, so blanking pixels
    // can never fall inside it.
    assign in_win = (px11 >= x_pos_q) && (px11 < x_pos_q + IMG_W_11) &&
                    (py11 >= y_pos_q) && (py11 < y_pos_q + IMG_H_11);

    // The strobe is combinational, so it is gated by reset to keep the ROM
    // idle while the block is held in reset with the sprite at (0,0).
    assign rom_rd_en = in_win & sys_rst_n;
    assign rom_addr  = addr_q;

    assign blank = (px11 >= H_V) || (py11 >= V_V);

    // -----------------------------------------------------------------
    // Motion: evaluated every cycle, committed only at frame end.
    // -----------------------------------------------------------------
    assign x_cur_s = signed'({1'b0, x_pos_q});
    assign y_cur_s = signed'({1'b0, y_pos_q});

    always_comb begin
        x_pos_d = x_pos_q;
        y_pos_d = y_pos_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        hit_x   = 1'b0;
        hit_y   = 1'b0;
        nx_s    = dir_x_q ? (x_cur_s - STEP_X_S) : (x_cur_s + STEP_X_S);
        ny_s    = dir_y_q ? (y_cur_s - STEP_Y_S) : (y_cur_s + STEP_Y_S);

        if (fe && !pause) begin
            if (nx_s > X_MAX_S) begin
                x_pos_d = X_MAX;
                dir_x_d = 1'b1;
                hit_x   = 1'b1;
            end else if (nx_s < 12'sd0) begin
                x_pos_d = 11'd0;
                dir_x_d = 1'b0;
                hit_x   = 1'b1;
            end else begin
                x_pos_d = nx_s[10:0];
            end

            if (ny_s > Y_MAX_S) begin
                y_pos_d = Y_MAX;
                dir_y_d = 1'b1;
                hit_y   = 1'b1;
            end else if (ny_s < 12'sd0) begin
                y_pos_d = 11'd0;
                dir_y_d = 1'b0;
                hit_y   = 1'b1;
            end else begin
                y_pos_d = ny_s[10:0];
            end
        end
    end

    // A corner hit contributes 2; the counter sticks at all-ones.
    assign hit_inc = {1'b0, hit_x} + {1'b0, hit_y};
    assign hit_sum = {1'b0, hit_q} + {15'd0, hit_inc};
    assign hit_d   = hit_sum[16] ? 16'hFFFF : hit_sum[15:0];

    // -----------------------------------------------------------------
    // Sprite ROM address: follows the window in raster order, restarts
    // every frame. Frame-end clear wins over a coincident window pixel.
    // -----------------------------------------------------------------
    always_comb begin
        addr_d = addr_q;
        if (fe) begin
            addr_d = '0;
        end else if (in_win) begin
            addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
        end
    end

    // -----------------------------------------------------------------
    // Background generator
    // -----------------------------------------------------------------
    always_comb begin
        bar_idx = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (px11 >= 11'(i * BAR_W)) begin
                bar_idx = 4'(i);
            end
        end

        bg_d = 16'h0000;
        if (!blank) begin
            unique case (bg_mode)
                2'd0: begin
                    case (bar_idx)
                        4'd0:    bg_d = C_RED;
                        4'd1:    bg_d = C_ORANGE;
                        4'd2:    bg_d = C_YELLOW;
                        4'd3:    bg_d = C_GREEN;
                        4'd4:    bg_d = C_CYAN;
                        4'd5:    bg_d = C_BLUE;
                        4'd6:    bg_d = C_PURPLE;
                        4'd7:    bg_d = C_BLACK;
                        4'd8:    bg_d = C_WHITE;
                        default: bg_d = C_GRAY;
                    endcase
                end
                2'd1: bg_d = bg_color;
                2'd2: bg_d = (pix_x[3] ^ pix_y[3]) ? 16'h0000 : bg_color;
                2'd3: bg_d = 16'h0000;
            endcase
        end
    end

    // -----------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------
    always_ff @(posedge tft_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x_pos_q <= '0;
            y_pos_q <= '0;
            dir_x_q <= 1'b0;
            dir_y_q <= 1'b0;
            addr_q  <= '0;
            hit_q   <= '0;
            tick_q  <= 1'b0;
            img_v_q <= 1'b0;
            bg_q    <= '0;
        end else begin
            x_pos_q <= x_pos_d;
            y_pos_q <= y_pos_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            addr_q  <= addr_d;
            hit_q   <= hit_d;
            tick_q  <= fe;
            img_v_q <= in_win;
            bg_q    <= bg_d;
        end
    end

    assign frame_tick = tick_q;
    assign hit_cnt    = hit_q;

    // ROM data for the pixel registered last cycle arrives now, so the
    // composite is combinational on rom_data and key_en.
    assign pix_data = (img_v_q && !(key_en && (rom_data == KEY_COLOR))) ? rom_data : bg_q;

endmodule

// File: tb/tb_tft_sprite_bounce.sv
module tb_tft_sprite_bounce;

    localparam logic [15:0] KEY = 16'hF81F;

    int cfg_h [2] = '{480, 8};
    int cfg_v [2] = '{272, 8};
    int cfg_w [2] = '{100, 4};
    int cfg_ih[2] = '{100, 4};
    int cfg_sx[2] = '{3, 2};
    int cfg_sy[2] = '{1, 2};

    logic [15:0] bars[10] = '{16'hF800, 16'hFD20, 16'hFFE0, 16'h07E0, 16'h07FF,
                              16'h001F, 16'h8010, 16'h0000, 16'hFFFF, 16'h8410};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT inputs and their staged next values
    logic        in_rst [2];
    logic [9:0]  in_px  [2];
    logic [9:0]  in_py  [2];
    logic        in_pause[2];
    logic        in_key [2];
    logic [1:0]  in_mode[2];
    logic [15:0] in_color[2];
    logic [15:0] in_rdata[2];

    logic        s_rst  [2];
    logic [9:0]  s_px   [2];
    logic [9:0]  s_py   [2];
    logic        s_pause[2];
    logic        s_key  [2];
    logic [1:0]  s_mode [2];
    logic [15:0] s_color[2];
    logic [15:0] s_rdata[2];

    logic [13:0] addr0;
    logic [3:0]  addr1;
    logic        rd0, rd1, tick0, tick1;
    logic [15:0] pix0, pix1, hit0, hit1;

    tft_sprite_bounce #(.H_VALID(480), .V_VALID(272), .IMG_W(100), .IMG_H(100),
                        .ADDR_W(14), .STEP_X(3), .STEP_Y(1), .KEY_COLOR(16'hF81F)) dut0 (
        .tft_clk(clk), .sys_rst_n(in_rst[0]), .pix_x(in_px[0]), .pix_y(in_py[0]),
        .pause(in_pause[0]), .key_en(in_key[0]), .bg_mode(in_mode[0]),
        .bg_color(in_color[0]), .rom_data(in_rdata[0]), .rom_addr(addr0),
        .rom_rd_en(rd0), .pix_data(pix0), .frame_tick(tick0), .hit_cnt(hit0));

    tft_sprite_bounce #(.H_VALID(8), .V_VALID(8), .IMG_W(4), .IMG_H(4),
                        .ADDR_W(4), .STEP_X(2), .STEP_Y(2), .KEY_COLOR(16'hF81F)) dut1 (
        .tft_clk(clk), .sys_rst_n(in_rst[1]), .pix_x(in_px[1]), .pix_y(in_py[1]),
        .pause(in_pause[1]), .key_en(in_key[1]), .bg_mode(in_mode[1]),
        .bg_color(in_color[1]), .rom_data(in_rdata[1]), .rom_addr(addr1),
        .rom_rd_en(rd1), .pix_data(pix1), .frame_tick(tick1), .hit_cnt(hit1));

    // Behavioural model state (per instance)
    int          mx[2], my[2], mdx[2], mdy[2], mhit[2], maddr[2], mtick[2], mimg[2];
    logic [15:0] mbg[2];
    int          fe_cnt[2];

    int  n_cmp = 0;
    int  n_err = 0;
    bit  rnd[2];
    int  pause_mode[2];    // 0 never, 1 random, 2 always
    bit  count_ticks = 0;
    int  tick_seen = 0;
    bit  corner_done = 0;

    task automatic cmp(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        mx[k] = 0; my[k] = 0; mdx[k] = 1; mdy[k] = 1; mhit[k] = 0;
        maddr[k] = 0; mtick[k] = 0; mimg[k] = 0; mbg[k] = 16'h0000;
    endtask

    function automatic logic [15:0] bg_of(input int k, input int x, input int y,
                                          input logic [1:0] mode, input logic [15:0] col);
        int bw, b;
        if (x >= cfg_h[k] || y >= cfg_v[k]) return 16'h0000;
        case (mode)
            2'd0: begin
                bw = cfg_h[k] / 10;
                b  = (bw == 0) ? 9 : x / bw;
                if (b > 9) b = 9;
                return bars[b];
            end
            2'd1: return col;
            2'd2: return (((x / 8) + (y / 8)) % 2 == 0) ? col : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit model_win(input int k);
        int x = int'(in_px[k]);
        int y = int'(in_py[k]);
        return in_rst[k] && x >= mx[k] && x < mx[k] + cfg_w[k] &&
               y >= my[k] && y < my[k] + cfg_ih[k];
    endfunction

    task automatic check(input int k);
        logic [15:0] exp_pix;
        logic        rd, tk;
        logic [15:0] px, ht;
        logic [31:0] ad;
        rd = (k == 0) ? rd0 : rd1;
        tk = (k == 0) ? tick0 : tick1;
        px = (k == 0) ? pix0 : pix1;
        ht = (k == 0) ? hit0 : hit1;
        ad = (k == 0) ? 32'(addr0) : 32'(addr1);
        if (mimg[k] != 0 && !(in_key[k] && in_rdata[k] == KEY)) exp_pix = in_rdata[k];
        else                                                   exp_pix = mbg[k];
        cmp("rom_rd_en", k, 32'(rd), 32'(model_win(k)));
        cmp("rom_addr", k, ad, 32'(maddr[k]));
        cmp("frame_tick", k, 32'(tk), 32'(mtick[k]));
        cmp("hit_cnt", k, 32'(ht), 32'(mhit[k]));
        cmp("pix_data", k, 32'(px), 32'(exp_pix));
    endtask

    task automatic axis_move(input int k, inout int pos, inout int dir,
                             input int step, input int lim, inout int hits);
        int n = pos + dir * step;
        if (n > lim)      begin pos = lim; dir = -1; hits++; end
        else if (n < 0)   begin pos = 0;   dir = 1;  hits++; end
        else              pos = n;
    endtask

    task automatic update(input int k);
        int  x = int'(in_px[k]);
        int  y = int'(in_py[k]);
        bit  fe, win;
        int  hits = 0;
        if (!in_rst[k]) return;
        fe  = (x == cfg_h[k] - 1) && (y == cfg_v[k] - 1);
        win = model_win(k);
        mtick[k] = fe;
        mimg[k]  = win;
        mbg[k]   = bg_of(k, x, y, in_mode[k], in_color[k]);
        if (fe)       maddr[k] = 0;
        else if (win) maddr[k] = (maddr[k] + 1) % (cfg_w[k] * cfg_ih[k]);
        if (fe) begin
            fe_cnt[k]++;
            if (!in_pause[k]) begin
                axis_move(k, mx[k], mdx[k], cfg_sx[k], cfg_h[k] - cfg_w[k], hits);
                axis_move(k, my[k], mdy[k], cfg_sy[k], cfg_v[k] - cfg_ih[k], hits);
                mhit[k] = mhit[k] + hits;
                if (mhit[k] > 65535) mhit[k] = 65535;
            end
        end
    endtask

    task automatic gen_rand(input int k);
        int r = int'($urandom % 10);
        int x, y;
        if (r < 4) begin
            x = mx[k] - 2 + int'($urandom % (cfg_w[k] + 4));
            y = my[k] - 2 + int'($urandom % (cfg_ih[k] + 4));
            if (x < 0) x = 0;
            if (y < 0) y = 0;
        end else if (r < 6) begin
            x = int'($urandom % 1024);
            y = int'($urandom % 1024);
        end else if (r == 6) begin
            x = cfg_h[k] - 1;
            y = cfg_v[k] - 1;
        end else begin
            x = int'(in_px[k]) + 1;
            y = int'(in_py[k]);
            if (x >= cfg_h[k] + 4) begin
                x = 0;
                y = y + 1;
                if (y >= cfg_v[k] + 2) y = 0;
            end
        end
        s_px[k]    = 10'(x);
        s_py[k]    = 10'(y);
        s_rdata[k] = ($urandom % 4 == 0) ? KEY : 16'($urandom);
        s_key[k]   = 1'($urandom);
        s_mode[k]  = 2'($urandom);
        s_color[k] = 16'($urandom);
        s_pause[k] = (pause_mode[k] == 2) ? 1'b1 :
                     (pause_mode[k] == 1) ? ($urandom % 4 == 0) : 1'b0;
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rnd[k]) gen_rand(k);
            in_rst[k]   = s_rst[k];
            in_px[k]    = s_px[k];
            in_py[k]    = s_py[k];
            in_pause[k] = s_pause[k];
            in_key[k]   = s_key[k];
            in_mode[k]  = s_mode[k];
            in_color[k] = s_color[k];
            in_rdata[k] = s_rdata[k];
            if (!in_rst[k]) model_reset(k);
        end
        #1;
        for (int k = 0; k < 2; k++) check(k);
        if (count_ticks && tick0) tick_seen++;
        if (!corner_done && fe_cnt[1] == 3) begin
            corner_done = 1;
            cmp("corner_hit_cnt", 1, 32'(hit1), 32'd2);
            cmp("corner_dir_x", 1, 32'(mdx[1]), 32'(-1));
            cmp("corner_dir_y", 1, 32'(mdy[1]), 32'(-1));
            pause_mode[1] = 1;
        end
        for (int k = 0; k < 2; k++) update(k);
    endtask

    task automatic drive0(input int x, input int y);
        s_px[0] = 10'(x);
        s_py[0] = 10'(y);
        cycle();
    endtask

    task automatic run_until_fe0(input int target, input string name);
        int guard = 0;
        while (fe_cnt[0] < target && guard < 20000) begin
            cycle();
            guard++;
        end
        if (fe_cnt[0] < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got %0d frames expected %0d", name, fe_cnt[0], target);
        end
    endtask

    initial begin
        int   sx, sy, sh;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            fe_cnt[k] = 0;
            rnd[k] = 1;
            pause_mode[k] = 0;
            s_rst[k] = 1'b0; s_px[k] = '0; s_py[k] = '0; s_pause[k] = 1'b0;
            s_key[k] = 1'b0; s_mode[k] = 2'd0; s_color[k] = '0; s_rdata[k] = '0;
            in_rst[k] = 1'b0; in_px[k] = '0; in_py[k] = '0; in_pause[k] = 1'b0;
            in_key[k] = 1'b0; in_mode[k] = 2'd0; in_color[k] = '0; in_rdata[k] = '0;
        end

        // Reset held while pixels scan
        for (int i = 0; i < 20; i++) begin
            cycle();
            cmp("rst_pix", 0, 32'(pix0), 32'd0);
            cmp("rst_rd_en", 0, 32'(rd0), 32'd0);
            cmp("rst_hit", 0, 32'(hit0), 32'd0);
            cmp("rst_tick", 0, 32'(tick0), 32'd0);
            cmp("rst_pix", 1, 32'(pix1), 32'd0);
        end

        // Frame 0 address walk on the default-size instance
        rnd[0] = 0;
        s_rst[0] = 1'b1; s_rst[1] = 1'b1;
        s_mode[0] = 2'd0; s_key[0] = 1'b0; s_pause[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            drive0(i, 0);
            cmp("walk_addr", 0, 32'(addr0), 32'(i));
            cmp("walk_rd_en", 0, 32'(rd0), 32'd1);
        end
        drive0(100, 0);
        cmp("edge_rd_en", 0, 32'(rd0), 32'd0);
        drive0(0, 1);
        cmp("line1_addr", 0, 32'(addr0), 32'd100);
        cmp("line1_rd_en", 0, 32'(rd0), 32'd1);
        drive0(479, 271);
        drive0(200, 200);
        cmp("fe_addr_clear", 0, 32'(addr0), 32'd0);
        cmp("fe_tick", 0, 32'(tick0), 32'd1);
        cmp("model_x_f1", 0, 32'(mx[0]), 32'd3);

        // Colour key: sprite now at (3,1)
        s_mode[0] = 2'd1; s_color[0] = 16'h1234; s_key[0] = 1'b1;
        drive0(5, 2);
        s_rdata[0] = KEY;
        drive0(300, 250);
        cmp("key_on_pix", 0, 32'(pix0), 32'h1234);
        drive0(5, 2);
        s_key[0] = 1'b0;
        drive0(300, 250);
        cmp("key_off_pix", 0, 32'(pix0), 32'hF81F);

        // Bounce on the right wall with STEP_X=3
        rnd[0] = 1;
        run_until_fe0(126, "frames126");
        cmp("model_x_f126", 0, 32'(mx[0]), 32'd378);
        run_until_fe0(127, "frames127");
        cmp("model_x_f127", 0, 32'(mx[0]), 32'd380);
        cmp("model_dir_f127", 0, 32'(mdx[0]), 32'(-1));
        cmp("model_hit_f127", 0, 32'(mhit[0]), 32'd1);
        if (fe_cnt[0] == 127) begin
            cycle();
            if (fe_cnt[0] == 127) cmp("hit_f127", 0, 32'(hit0), 32'd1);
        end
        run_until_fe0(128, "frames128");
        cmp("model_x_f128", 0, 32'(mx[0]), 32'd377);

        // Pause across five frame ends
        rnd[0] = 0;
        s_pause[0] = 1'b0;
        drive0(600, 600);
        drive0(600, 600);
        sx = mx[0]; sy = my[0]; sh = int'(hit0);
        pause_mode[0] = 2;
        rnd[0] = 1;
        count_ticks = 1;
        tick_seen = 0;
        run_until_fe0(fe_cnt[0] + 5, "pause_frames");
        rnd[0] = 0;
        s_pause[0] = 1'b1;
        drive0(600, 600);
        count_ticks = 0;
        cmp("pause_ticks", 0, 32'(tick_seen), 32'd5);
        cmp("pause_hit", 0, 32'(hit0), 32'(sh));
        cmp("pause_x", 0, 32'(mx[0]), 32'(sx));
        cmp("pause_y", 0, 32'(my[0]), 32'(sy));
        pause_mode[0] = 1;
        rnd[0] = 1;

        cmp("corner_reached", 1, 32'(corner_done), 32'd1);

        // Reset mid-line on the small instance
        rnd[1] = 0;
        s_px[1] = 10'd1; s_py[1] = 10'd1;
        s_rst[1] = 1'b0;
        cycle();
        cmp("midrst_hit", 1, 32'(hit1), 32'd0);
        cmp("midrst_rd_en", 1, 32'(rd1), 32'd0);
        cmp("midrst_pix", 1, 32'(pix1), 32'd0);
        cmp("midrst_tick", 1, 32'(tick1), 32'd0);
        cmp("midrst_addr", 1, 32'(addr1), 32'd0);
        s_rst[1] = 1'b1;
        s_px[1] = 10'd2; s_py[1] = 10'd0;
        cycle();
        cmp("post_rst_rd_en", 1, 32'(rd1), 32'd1);
        rnd[1] = 1;

        for (int i = 0; i < 400; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
